// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command opcodes, decoder
// state encoding and the fixed register-file slots used for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_ALU_A   = 3'd4,
    ST_ALU_B   = 3'd5,
    ST_ALU_FUN = 3'd6
  } state_t;

endpackage

// File: rtl/rx_frame_timer.sv
// Saturating inter-byte idle counter. expire is high while the count sits at
// LIMIT; a LIMIT of zero disables expiry entirely.
module rx_frame_timer #(
  parameter logic [15:0] LIMIT = 16'd5000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned LIMIT_I = LIMIT;
  localparam int CW = (LIMIT_I == 0) ? 1 : $clog2(LIMIT_I + 1);
  localparam logic [CW-1:0] TOP = CW'(LIMIT_I);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (LIMIT_I != 0) && (count == TOP);

endmodule

// File: rtl/rx_cmd_decoder.sv
// Decodes UART byte frames into one-cycle register-file / ALU requests.
// Partial frames are dropped on an inter-byte timeout or an unknown opcode.
module rx_cmd_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 4,
  parameter int          FUN_WIDTH  = 4,
  parameter logic [15:0] TIMEOUT    = 16'd5000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  GATE_EN,
  output logic                  FRAME_ERR
);

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_d, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_d;
  logic rf_wr_en_d, rf_rd_en_d, alu_en_d, gate_en_d, frame_err_d;
  logic timer_clear, expire;

  // The timer only runs while a frame is open; any accepted byte restarts it.
  assign timer_clear = (state == ST_IDLE) || RX_D_VLD;

  rx_frame_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .clear (timer_clear),
    .enable(1'b1),
    .expire(expire)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      wr_addr    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      ALU_EN     <= 1'b0;
      ALU_FUN    <= '0;
      GATE_EN    <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      state      <= next_state;
      wr_addr    <= wr_addr_d;
      RF_WR_EN   <= rf_wr_en_d;
      RF_RD_EN   <= rf_rd_en_d;
      RF_ADDR    <= rf_addr_d;
      RF_WR_DATA <= rf_wr_data_d;
      ALU_EN     <= alu_en_d;
      ALU_FUN    <= alu_fun_d;
      GATE_EN    <= gate_en_d;
      FRAME_ERR  <= frame_err_d;
    end
  end

  // A byte arriving on the expiry cycle takes priority over the abort.
  always_comb begin
    next_state   = state;
    wr_addr_d    = wr_addr;
    rf_addr_d    = RF_ADDR;
    rf_wr_data_d = RF_WR_DATA;
    alu_fun_d    = ALU_FUN;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    frame_err_d  = 1'b0;

    if (RX_D_VLD) begin
      case (state)
        ST_IDLE: begin
          case (RX_P_DATA)
            DATA_WIDTH'(CMD_RF_WR):   next_state = ST_WR_ADDR;
            DATA_WIDTH'(CMD_RF_RD):   next_state = ST_RD_ADDR;
            DATA_WIDTH'(CMD_ALU_OP):  next_state = ST_ALU_A;
            DATA_WIDTH'(CMD_ALU_NOP): next_state = ST_ALU_FUN;
            default:                  frame_err_d = 1'b1;
          endcase
        end
        ST_WR_ADDR: begin
          wr_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          next_state = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          rf_addr_d    = wr_addr;
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          next_state   = ST_IDLE;
        end
        ST_RD_ADDR: begin
          rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          next_state = ST_IDLE;
        end
        ST_ALU_A: begin
          rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          next_state   = ST_ALU_B;
        end
        ST_ALU_B: begin
          rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          next_state   = ST_ALU_FUN;
        end
        ST_ALU_FUN: begin
          alu_fun_d  = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d   = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end else if (expire && (state != ST_IDLE)) begin
      next_state  = ST_IDLE;
      frame_err_d = 1'b1;
    end

    gate_en_d = alu_en_d || (next_state == ST_ALU_A) ||
                (next_state == ST_ALU_B) || (next_state == ST_ALU_FUN);
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: strobes are checked against a queue of
// expected events, each tagged with the cycle it must appear in.
module tb_rx_cmd_decoder;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ALU  = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       CLK, RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       RF_WR_EN, RF_RD_EN, ALU_EN, GATE_EN, FRAME_ERR;
  logic [3:0] RF_ADDR, ALU_FUN;
  logic [7:0] RF_WR_DATA;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  rx_cmd_decoder #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .FUN_WIDTH (4),
    .TIMEOUT   (16'd10)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (RX_P_DATA),
    .RX_D_VLD  (RX_D_VLD),
    .RF_WR_EN  (RF_WR_EN),
    .RF_RD_EN  (RF_RD_EN),
    .RF_ADDR   (RF_ADDR),
    .RF_WR_DATA(RF_WR_DATA),
    .ALU_EN    (ALU_EN),
    .ALU_FUN   (ALU_FUN),
    .GATE_EN   (GATE_EN),
    .FRAME_ERR (FRAME_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string prefix);
    checkOutput({prefix, "_rf_wr_en"},   32'(RF_WR_EN),   0);
    checkOutput({prefix, "_rf_rd_en"},   32'(RF_RD_EN),   0);
    checkOutput({prefix, "_rf_addr"},    32'(RF_ADDR),    0);
    checkOutput({prefix, "_rf_wr_data"}, 32'(RF_WR_DATA), 0);
    checkOutput({prefix, "_alu_en"},     32'(ALU_EN),     0);
    checkOutput({prefix, "_alu_fun"},    32'(ALU_FUN),    0);
    checkOutput({prefix, "_gate_en"},    32'(GATE_EN),    0);
    checkOutput({prefix, "_frame_err"},  32'(FRAME_ERR),  0);
  endtask

  task automatic expectAt(input int kind, input logic [7:0] a, input logic [7:0] d, input int due);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Drives one byte for one cycle; the expected strobe (if any) is due in
  // the cycle right after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input int kind,
                               input logic [7:0] a, input logic [7:0] d);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
    if (kind != K_NONE) expectAt(kind, a, d, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("unexpected_strobe", 32'(kind), 32'(K_NONE));
    end else begin
      e = sb.pop_front();
      checkOutput("strobe_kind", 32'(kind), 32'(e.kind));
      checkOutput("strobe_cycle", 32'(cyc), 32'(e.due));
      if (kind == K_WR || kind == K_RD) checkOutput("strobe_addr", 32'(a), 32'(e.addr));
      if (kind == K_WR || kind == K_ALU) checkOutput("strobe_data", 32'(d), 32'(e.data));
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (RF_WR_EN)  observe(K_WR,  {4'h0, RF_ADDR}, RF_WR_DATA);
      if (RF_RD_EN)  observe(K_RD,  {4'h0, RF_ADDR}, 8'h00);
      if (ALU_EN)    observe(K_ALU, 8'h00, {4'h0, ALU_FUN});
      if (FRAME_ERR) observe(K_ERR, 8'h00, 8'h00);
    end
  end

  initial begin
    RST       = 1'b0;
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'h00;
    idle(3);
    checkAllZero("por");
    @(negedge CLK);
    RST = 1'b1;
    idle(2);

    // write and read frames
    applyStimulus(8'hAA, K_NONE, 0, 0);
    applyStimulus(8'h05, K_NONE, 0, 0);
    applyStimulus(8'h3C, K_WR, 8'h05, 8'h3C);
    idle(2);
    applyStimulus(8'hBB, K_NONE, 0, 0);
    applyStimulus(8'h0F, K_RD, 8'h0F, 0);
    idle(2);

    // ALU frame with operands, gate enable window
    checkOutput("gate_before_cc", 32'(GATE_EN), 0);
    applyStimulus(8'hCC, K_NONE, 0, 0);
    checkOutput("gate_after_cc", 32'(GATE_EN), 1);
    applyStimulus(8'h12, K_WR, 8'h00, 8'h12);
    checkOutput("gate_opa", 32'(GATE_EN), 1);
    applyStimulus(8'h34, K_WR, 8'h01, 8'h34);
    applyStimulus(8'h01, K_ALU, 0, 8'h01);
    checkOutput("gate_alu_en_cycle", 32'(GATE_EN), 1);
    idle(1);
    checkOutput("gate_after_alu", 32'(GATE_EN), 0);

    // ALU no-op frame
    applyStimulus(8'hDD, K_NONE, 0, 0);
    checkOutput("gate_after_dd", 32'(GATE_EN), 1);
    applyStimulus(8'h07, K_ALU, 0, 8'h07);
    checkOutput("gate_dd_alu_en", 32'(GATE_EN), 1);
    idle(1);
    checkOutput("gate_after_dd_alu", 32'(GATE_EN), 0);

    // unknown opcode, then back-to-back write
    applyStimulus(8'h55, K_ERR, 0, 0);
    idle(2);
    applyStimulus(8'hAA, K_NONE, 0, 0);
    applyStimulus(8'h01, K_NONE, 0, 0);
    applyStimulus(8'hFF, K_WR, 8'h01, 8'hFF);
    idle(2);

    // timeout abort: error due 11 cycles after the last accepted byte
    applyStimulus(8'hAA, K_NONE, 0, 0);
    applyStimulus(8'h03, K_NONE, 0, 0);
    expectAt(K_ERR, 0, 0, cyc + 11);
    idle(13);
    applyStimulus(8'hBB, K_NONE, 0, 0);
    applyStimulus(8'h02, K_RD, 8'h02, 0);
    idle(2);

    // timeout in the ALU path drops the gate enable
    applyStimulus(8'hCC, K_NONE, 0, 0);
    applyStimulus(8'h12, K_WR, 8'h00, 8'h12);
    expectAt(K_ERR, 0, 0, cyc + 11);
    idle(12);
    checkOutput("gate_after_abort", 32'(GATE_EN), 0);
    idle(1);

    // byte on the exact expiry cycle is processed normally
    applyStimulus(8'hAA, K_NONE, 0, 0);
    applyStimulus(8'h03, K_NONE, 0, 0);
    idle(10);
    applyStimulus(8'h44, K_WR, 8'h03, 8'h44);
    idle(3);

    // asynchronous reset mid-frame discards the partial frame
    applyStimulus(8'hAA, K_NONE, 0, 0);
    applyStimulus(8'h05, K_NONE, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    checkAllZero("mid_rst");
    idle(2);
    RST = 1'b1;
    idle(1);
    applyStimulus(8'h3C, K_ERR, 0, 0);
    idle(3);

    checkOutput("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
